seg7_display_arbiter: RTL and testbench
=======================================

// Module: seg7_display_arbiter
// PURPOSE
//  Shares the 4-digit seven-segment display between two requesters: the mouse-status path
//  (A, packets from the PS/2 receiver) and the microprocessor bus (B, memory-mapped writes).
//  Owns digit scan timing and tear-free frame latching, and feeds {seg_select, bin, dot} to seg7decoder.
//  B pre-empts A for a hold window; A regains the display on timeout or explicit release.
// PARAMETERS
//  REFRESH_DIV  250000    clk_sys cycles per digit step (200 Hz at 50 MHz); sim override 4
//  HOLD_CYCLES  50000000  B ownership hold after last B write (1 s); sim override 100
//  BASE_ADDR    8'hD0     bus base; +0 digits[7:0], +1 digits[15:8], +2 dots[3:0], +3 ctrl
// PORTS
//  clk_sys     in   1   system clock, 50 MHz
//  rst_n       in   1   asynchronous active-low reset
//  a_vld       in   1   requester A strobe, 1 cycle
//  a_digits    in   16  A nibbles; [3:0]=digit0 .. [15:12]=digit3
//  a_dots      in   4   A decimal points; bit n -> digit n
//  bus_we      in   1   bus write strobe, 1 cycle
//  bus_addr    in   8   bus address
//  bus_data    in   8   bus write data
//  seg_select  out  2   digit index to decoder
//  bin         out  4   nibble for selected digit
//  dot         out  1   decimal point for selected digit
//  owner_b     out  1   1 = bus owns display (LED/debug)
// BEHAVIOUR
//  Reset: every register 0: seg_select, bin, dot, owner_b, shadows, frame, counters; state OWN_A.
//  Shadows: A shadow {a_digits,a_dots} loads on every a_vld, regardless of owner.
//   B shadow: write to +0/+1/+2 loads that byte (+2 uses bus_data[3:0]); addr outside +0..+3 ignored.
//  FSM OWN_A/OWN_B (owner_b = state==OWN_B, registered):
//   OWN_A -> OWN_B on bus_we to +0..+2; hold_cnt <= HOLD_CYCLES-1.
//   OWN_B: any write to +0..+2 reloads hold_cnt; else hold_cnt decrements each cycle.
//   OWN_B -> OWN_A when hold_cnt==0 (no reload that cycle) or write to +3 with bus_data[0]=1.
//   Same-cycle release and +0..+2 write impossible (single address); release write wins
//   over expiry (both -> OWN_A). Write to +3 with bus_data[0]=0 is a no-op.
//   a_vld concurrent with B write: A shadow still updates, ownership follows B rule.
//  Scan: ref_cnt counts 0..REFRESH_DIV-1 and wraps; tick = 1-cycle pulse at wrap.
//   On tick seg_select increments mod 4 (3->0 wraps).
//  Frame latch: on tick where seg_select==3 (next digit 0), frame <= shadow of current owner
//   (registered state). Ownership change mid-frame shows only from next frame: no tearing.
//  Output: bin/dot registered from frame[seg_select]; lag seg_select by exactly 1 clk_sys.
//   Shadow change reaches display within one full frame (4*REFRESH_DIV cycles) plus 2 cycles.
//  hold_cnt width = $clog2(HOLD_CYCLES); ref_cnt width = $clog2(REFRESH_DIV); no saturation.
//  Reset mid-operation: immediate return to reset values, state OWN_A, scan restarts at digit 0.
// TESTING (REFRESH_DIV=4, HOLD_CYCLES=100)
//  1 Reset, a_vld digits=16'h1234 dots=4'b0001 -> after next frame latch, digits 0..3 show
//    bin 4,3,2,1, dot=1 only on digit 0; owner_b=0.
//  2 Bus write +1=8'hAB, +0=8'hCD -> owner_b=1 next cycle; following frame shows D,C,B,A;
//    A packets during hold not displayed.
//  3 No further B writes -> owner_b falls exactly 100 cycles after last +0..+2 write; next frame
//    shows latest A shadow.
//  4 Write +3=8'h01 while OWN_B -> owner_b=0 next cycle; +3=8'h00 and addr 8'hD7 -> no effect.
//  5 Ownership flip while seg_select=1 -> digits 2,3 of current frame keep old source; check
//    bin lags seg_select by 1 cycle and tick period is 4 cycles.
//  6 Assert rst_n low mid-hold with hold_cnt=50 -> all outputs 0, OWN_A; scan restarts at digit 0.

Source files
------------

// File: rtl/seg7_display_arbiter.sv
// Shares a 4-digit seven-segment display between the mouse-status path (A) and the bus (B).
// Owns digit scan timing and latches whole frames at digit-0 boundaries so the display never tears.
module seg7_display_arbiter #(
  parameter int          REFRESH_DIV = 250000,
  parameter int          HOLD_CYCLES = 50000000,
  parameter logic [7:0]  BASE_ADDR   = 8'hD0
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        a_vld,
  input  logic [15:0] a_digits,
  input  logic [3:0]  a_dots,
  input  logic        bus_we,
  input  logic [7:0]  bus_addr,
  input  logic [7:0]  bus_data,
  output logic [1:0]  seg_select,
  output logic [3:0]  bin,
  output logic        dot,
  output logic        owner_b
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic {OWN_A = 1'b0, OWN_B = 1'b1} state_e;

  state_e         state_q, state_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic [RW-1:0]  ref_q;
  logic [1:0]     sel_q;
  logic [15:0]    a_dig_q, b_dig_q, fr_dig_q;
  logic [3:0]     a_dot_q, b_dot_q, fr_dot_q;
  logic [3:0]     bin_q;
  logic           dot_q;

  logic [7:0]     off;
  logic           b_wr, b_rel, tick;

  // Offset arithmetic keeps the decode correct even when BASE_ADDR sits near 8'hFF.
  assign off   = bus_addr - BASE_ADDR;
  assign b_wr  = bus_we && (off < 8'd3);
  assign b_rel = bus_we && (off == 8'd3) && bus_data[0];
  assign tick  = (ref_q == RW'(REFRESH_DIV - 1));

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OWN_A;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // Release beats expiry; any data write while owned restarts the hold window.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      OWN_A: begin
        if (b_wr) begin
          state_d = OWN_B;
          hold_d  = HW'(HOLD_CYCLES - 1);
        end
      end
      OWN_B: begin
        if (b_rel)              state_d = OWN_A;
        else if (b_wr)          hold_d  = HW'(HOLD_CYCLES - 1);
        else if (hold_q == '0)  state_d = OWN_A;
        else                    hold_d  = hold_q - HW'(1);
      end
      default: state_d = OWN_A;
    endcase
  end

  always_comb begin
    owner_b = (state_q == OWN_B);
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      a_dig_q <= '0;
      a_dot_q <= '0;
      b_dig_q <= '0;
      b_dot_q <= '0;
    end else begin
      if (a_vld) begin
        a_dig_q <= a_digits;
        a_dot_q <= a_dots;
      end
      if (b_wr) begin
        case (off[1:0])
          2'd0:    b_dig_q[7:0]  <= bus_data;
          2'd1:    b_dig_q[15:8] <= bus_data;
          default: b_dot_q       <= bus_data[3:0];
        endcase
      end
    end
  end

  // Frame is refreshed only as the scan wraps back to digit 0, from the registered owner.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      ref_q    <= '0;
      sel_q    <= '0;
      fr_dig_q <= '0;
      fr_dot_q <= '0;
      bin_q    <= '0;
      dot_q    <= 1'b0;
    end else begin
      ref_q <= tick ? '0 : ref_q + RW'(1);
      if (tick) begin
        sel_q <= sel_q + 2'd1;
        if (sel_q == 2'd3) begin
          fr_dig_q <= (state_q == OWN_B) ? b_dig_q : a_dig_q;
          fr_dot_q <= (state_q == OWN_B) ? b_dot_q : a_dot_q;
        end
      end
      bin_q <= fr_dig_q[{sel_q, 2'b00} +: 4];
      dot_q <= fr_dot_q[sel_q];
    end
  end

  assign seg_select = sel_q;
  assign bin        = bin_q;
  assign dot        = dot_q;

endmodule

// File: tb/tb_seg7_display_arbiter.sv
// Randomized and directed bench for seg7_display_arbiter against a cycle-count based reference model.
module tb_seg7_display_arbiter;

  localparam int         RD   = 4;
  localparam int         HOLD = 100;
  localparam logic [7:0] BASE = 8'hD0;

  logic        clk_sys = 1'b0;
  logic        rst_n   = 1'b0;
  logic        a_vld   = 1'b0;
  logic [15:0] a_digits = '0;
  logic [3:0]  a_dots   = '0;
  logic        bus_we   = 1'b0;
  logic [7:0]  bus_addr = '0;
  logic [7:0]  bus_data = '0;
  logic [1:0]  seg_select;
  logic [3:0]  bin;
  logic        dot;
  logic        owner_b;

  seg7_display_arbiter #(.REFRESH_DIV(RD), .HOLD_CYCLES(HOLD), .BASE_ADDR(BASE)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .a_vld(a_vld), .a_digits(a_digits), .a_dots(a_dots),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_data(bus_data),
    .seg_select(seg_select), .bin(bin), .dot(dot), .owner_b(owner_b)
  );

  always #5 clk_sys = ~clk_sys;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: scan position from cycle count, ownership as a deadline.
  int          m_n;
  bit          m_own;
  int          m_dead;
  logic [15:0] m_adig, m_bdig, m_fdig;
  logic [3:0]  m_adot, m_bdot, m_fdot;
  logic [3:0]  m_bin;
  logic        m_dot;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_n = 0; m_own = 0; m_dead = 0;
    m_adig = '0; m_bdig = '0; m_fdig = '0;
    m_adot = '0; m_bdot = '0; m_fdot = '0;
    m_bin = '0; m_dot = 1'b0;
  endtask

  task automatic model_edge();
    int         sel;
    logic [7:0] off;
    bit         bwr, rel;
    sel   = (m_n / RD) % 4;
    m_bin = m_fdig[sel*4 +: 4];
    m_dot = m_fdot[sel];
    if ((m_n % RD) == RD - 1 && sel == 3) begin
      m_fdig = m_own ? m_bdig : m_adig;
      m_fdot = m_own ? m_bdot : m_adot;
    end
    off = bus_addr - BASE;
    bwr = bus_we && (off < 8'd3);
    rel = bus_we && (off == 8'd3) && bus_data[0];
    if (!m_own) begin
      if (bwr) begin
        m_own  = 1;
        m_dead = m_n + HOLD;
      end
    end else if (rel) begin
      m_own = 0;
    end else if (bwr) begin
      m_dead = m_n + HOLD;
    end else if (m_n == m_dead) begin
      m_own = 0;
    end
    if (a_vld) begin
      m_adig = a_digits;
      m_adot = a_dots;
    end
    if (bwr) begin
      if (off == 8'd0)      m_bdig[7:0]  = bus_data;
      else if (off == 8'd1) m_bdig[15:8] = bus_data;
      else                  m_bdot       = bus_data[3:0];
    end
    m_n++;
  endtask

  task automatic compare();
    check("seg_select", 32'(seg_select), 32'((m_n / RD) % 4));
    check("bin",        32'(bin),        32'(m_bin));
    check("dot",        32'(dot),        32'(m_dot));
    check("owner_b",    32'(owner_b),    32'(m_own));
  endtask

  task automatic cycle();
    @(posedge clk_sys);
    if (!rst_n) model_reset();
    else        model_edge();
    #1;
    compare();
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cycle();
  endtask

  task automatic bus_wr(input logic [7:0] addr, input logic [7:0] data);
    bus_we = 1'b1; bus_addr = addr; bus_data = data;
    cycle();
    bus_we = 1'b0;
  endtask

  task automatic a_pkt(input logic [15:0] dig, input logic [3:0] dt);
    a_vld = 1'b1; a_digits = dig; a_dots = dt;
    cycle();
    a_vld = 1'b0;
  endtask

  initial begin
    model_reset();
    idle(3);
    rst_n = 1'b1;

    // Scenario: A packet shown after next frame latch
    a_pkt(16'h1234, 4'b0001);
    idle(40);
    check("owner_idle", 32'(owner_b), 32'd0);

    // Scenario: bus takes over, A packets hidden during hold
    bus_wr(BASE + 8'd1, 8'hAB);
    check("owner_take", 32'(owner_b), 32'd1);
    bus_wr(BASE, 8'hCD);
    a_pkt(16'h5678, 4'hF);
    idle(30);

    // Scenario: hold expiry, A shadow returns
    idle(110);
    check("owner_expired", 32'(owner_b), 32'd0);
    idle(20);

    // Scenario: release writes and ignored writes
    bus_wr(BASE + 8'd2, 8'h05);
    bus_wr(BASE + 8'd3, 8'h00);
    check("owner_noop_rel", 32'(owner_b), 32'd1);
    bus_wr(8'hD7, 8'h01);
    check("owner_bad_addr", 32'(owner_b), 32'd1);
    bus_wr(BASE + 8'd3, 8'h01);
    check("owner_release", 32'(owner_b), 32'd0);
    idle(20);

    // Scenario: ownership flip mid-frame
    for (int i = 0; i < 8 && seg_select != 2'd1; i++) cycle();
    bus_wr(BASE, 8'h99);
    idle(20);

    // Scenario: reset mid-hold with 50 cycles remaining
    bus_wr(BASE, 8'h42);
    idle(49);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare();
    check("owner_rst", 32'(owner_b), 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(12);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      a_vld    = ($urandom_range(7) == 0);
      a_digits = 16'($urandom);
      a_dots   = 4'($urandom);
      bus_we   = ($urandom_range(29) == 0);
      case ($urandom_range(5))
        0: bus_addr = BASE;
        1: bus_addr = BASE + 8'd1;
        2: bus_addr = BASE + 8'd2;
        3: bus_addr = BASE + 8'd3;
        4: bus_addr = BASE + 8'd7;
        default: bus_addr = 8'($urandom);
      endcase
      bus_data = 8'($urandom);
      cycle();
      a_vld  = 1'b0;
      bus_we = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
